// File: rtl/core_ctrl_if.sv
// core_ctrl request/status and corelet instruction bus.
// master drives inst/busy/done; slave issues start.
interface core_ctrl_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [33:0] inst;

  modport master (
    input  start,
    output busy,
    output done,
    output inst
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  inst
  );
endinterface

// File: rtl/core_ctrl.sv
// Convolution-pass sequencer for the corelet, xmem and pmem.
// Drives a registered 34-bit instruction word each cycle.
module core_ctrl #(
  parameter int          col    = 8,
  parameter int          row    = 8,
  parameter int          LEN    = 36,
  parameter int          KIJ    = 9,
  parameter int          DRAIN  = 16,
  parameter logic [10:0] W_BASE = 11'd64
) (
  input  logic        clk,
  input  logic        reset,
  core_ctrl_if.master bus
);

  localparam int CW = 12;
  localparam int AW = 11;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WFILL,
    S_WLOAD,
    S_AFILL,
    S_EXEC,
    S_DRAIN,
    S_OUT,
    S_ACC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   kij_q, kij_d;
  logic [CW-1:0]   o_q, o_d;
  logic [CW-1:0]   span;
  logic            last;
  logic [33:0]     inst_q, inst_d;
  logic            busy_q, done_q;

  // Step count of the current state; i wraps at the last step.
  always_comb begin
    span = CW'(1);
    unique case (state_q)
      S_WFILL: span = CW'(col + 1);
      S_WLOAD: span = CW'(col + row);
      S_AFILL: span = CW'(LEN + 1);
      S_EXEC:  span = CW'(LEN);
      S_DRAIN: span = CW'(DRAIN);
      S_OUT:   span = CW'(LEN + 1);
      S_ACC:   span = CW'(KIJ + 3);
      default: span = CW'(1);
    endcase
    last = (i_q == span - CW'(1));
  end

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    i_d     = last ? '0 : i_q + CW'(1);
    kij_d   = kij_q;
    o_d     = o_q;
    unique case (state_q)
      S_IDLE: begin
        i_d = '0;
        if (bus.start) begin
          state_d = S_WFILL;
          kij_d   = '0;
          o_d     = '0;
        end
      end
      S_WFILL: if (last) state_d = S_WLOAD;
      S_WLOAD: if (last) state_d = S_AFILL;
      S_AFILL: if (last) state_d = S_EXEC;
      S_EXEC:  if (last) state_d = S_DRAIN;
      S_DRAIN: if (last) state_d = S_OUT;
      S_OUT: begin
        if (last) begin
          if (kij_q < CW'(KIJ - 1)) begin
            kij_d   = kij_q + CW'(1);
            state_d = S_WFILL;
          end else begin
            o_d     = '0;
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (last) begin
          if (o_q == CW'(LEN - 1)) state_d = S_DONE;
          else                     o_d     = o_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction word for the upcoming cycle, decoded from next state.
  always_comb begin
    inst_d = IDLE_W;
    unique case (state_d)
      S_WFILL: begin
        if (i_d < CW'(col)) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = W_BASE + AW'(kij_d) * AW'(col) + AW'(i_d);
        end
        if (i_d != '0) inst_d[2] = 1'b1;
      end
      S_WLOAD: begin
        if (i_d < CW'(col)) begin
          inst_d[3] = 1'b1;
          inst_d[0] = 1'b1;
        end
      end
      S_AFILL: begin
        if (i_d < CW'(LEN)) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = AW'(i_d);
        end
        if (i_d != '0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      S_OUT: begin
        if (i_d < CW'(LEN)) inst_d[6] = 1'b1;
        if (i_d != '0) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = AW'(kij_d) * AW'(LEN) + AW'(i_d) - AW'(1);
        end
      end
      S_ACC: begin
        if (i_d < CW'(KIJ)) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = AW'(i_d) * AW'(LEN) + AW'(o_d);
        end
        if (i_d != '0 && i_d <= CW'(KIJ)) inst_d[33] = 1'b1;
        if (i_d == CW'(KIJ + 1)) inst_d[5] = 1'b1;
        if (i_d == CW'(KIJ + 2)) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = AW'(KIJ) * AW'(LEN) + AW'(o_d);
        end
      end
      default: inst_d = IDLE_W;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      kij_q   <= '0;
      o_q     <= '0;
      inst_q  <= IDLE_W;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      kij_q   <= kij_d;
      o_q     <= o_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: per-cycle scoreboard of the inst stream,
// plus busy/done timing, stray start and mid-pass reset.
module tb_core_ctrl;

  localparam logic [33:0] IW = 34'h1800C0000;
  localparam int PASS = 1791;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [33:0] sbq[$];

  core_ctrl_if bus();

  core_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [33:0] w);
    sbq.push_back(w);
  endtask

  // Expected word for every cycle of one pass, straight from the
  // instruction table.
  task automatic gen_pass();
    logic [33:0] w;
    sbq.delete();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 9; i++) begin
        w = IW;
        if (i < 8) begin
          w[19] = 1'b0;
          w[17:7] = 11'(64 + k * 8 + i);
        end
        if (i >= 1) w[2] = 1'b1;
        push(w);
      end
      for (int i = 0; i < 16; i++) begin
        w = IW;
        if (i < 8) begin
          w[3] = 1'b1;
          w[0] = 1'b1;
        end
        push(w);
      end
      for (int i = 0; i < 37; i++) begin
        w = IW;
        if (i < 36) begin
          w[19] = 1'b0;
          w[17:7] = 11'(i);
        end
        if (i >= 1) w[2] = 1'b1;
        push(w);
      end
      for (int i = 0; i < 36; i++) begin
        w = IW;
        w[3] = 1'b1;
        w[1] = 1'b1;
        push(w);
      end
      for (int i = 0; i < 16; i++) push(IW);
      for (int j = 0; j < 37; j++) begin
        w = IW;
        if (j < 36) w[6] = 1'b1;
        if (j >= 1) begin
          w[32] = 1'b0;
          w[31] = 1'b0;
          w[30:20] = 11'(k * 36 + j - 1);
        end
        push(w);
      end
    end
    for (int o = 0; o < 36; o++) begin
      for (int c = 0; c < 12; c++) begin
        w = IW;
        if (c < 9) begin
          w[32] = 1'b0;
          w[30:20] = 11'(c * 36 + o);
        end
        if (c >= 1 && c <= 9) w[33] = 1'b1;
        if (c == 10) w[5] = 1'b1;
        if (c == 11) begin
          w[32] = 1'b0;
          w[31] = 1'b0;
          w[30:20] = 11'(324 + o);
        end
        push(w);
      end
    end
  endtask

  // Pulse start; returns at the sample point of the first W_FILL cycle.
  task automatic kick();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at cycle 1 of a pass. stray: cycle to pulse start (0=none);
  // stop: cycle to bail out at (0=full); chain: restart at cycle 1793.
  task automatic run_pass(input int stray, input int stop,
                          input bit chain);
    logic [33:0] e;
    int ndone;
    int done_at;
    ndone = 0;
    done_at = 0;
    gen_pass();
    for (int c = 1; c <= PASS + 2; c++) begin
      if (c <= PASS) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 64'(c), 64'(0));
          e = IW;
        end else begin
          e = sbq.pop_front();
        end
      end else begin
        e = IW;
      end
      chk($sformatf("inst@%0d", c), 64'(bus.inst), 64'(e));
      chk($sformatf("busy@%0d", c), 64'(bus.busy),
          64'(c <= PASS + 1));
      if (bus.done) begin
        ndone++;
        done_at = c;
      end
      if (c == stop) return;
      bus.start = (c == stray) || (chain && c == PASS + 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_n", 64'(ndone), 64'(1));
    chk("done_at", 64'(done_at), 64'(PASS + 1));
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_inst", 64'(bus.inst), 64'(IW));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
    end

    // Plain pass, chained straight into a pass with a stray start.
    kick();
    run_pass(0, 0, 1'b1);
    run_pass(100, 0, 1'b0);

    // Reset during EXEC of kij=4, then a clean full replay.
    kick();
    run_pass(0, 671, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_inst", 64'(bus.inst), 64'(IW));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_inst", 64'(bus.inst), 64'(IW));
    chk("post_rst_busy", 64'(bus.busy), 64'(0));
    kick();
    run_pass(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
